// File: rtl/keyboard_keymap_pkg.sv
// Shared definitions for the PS/2 set-2 keymap decoder.
//   PS2_EXT / PS2_BRK  : E0 extended prefix and F0 break prefix bytes
//   key_code_t         : {ext, code} key identity; ext=1 means E0-prefixed
//   DEFAULT_MAP        : Left arrow, Right arrow, Space, Esc (index 0..3)
//   kbd_state_t        : prefix tracking states
//   is_ignored()       : bytes dropped when no prefix is pending
package keymap_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] PS2_IGN_E1 = 8'hE1;
    localparam logic [7:0] PS2_IGN_AA = 8'hAA;
    localparam logic [7:0] PS2_IGN_FA = 8'hFA;
    localparam logic [7:0] PS2_IGN_FE = 8'hFE;
    localparam logic [7:0] PS2_IGN_00 = 8'h00;
    localparam logic [7:0] PS2_IGN_FF = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_code_t;

    localparam key_code_t KEY_LEFT  = '{ext: 1'b1, code: 8'h6B};
    localparam key_code_t KEY_RIGHT = '{ext: 1'b1, code: 8'h74};
    localparam key_code_t KEY_SPACE = '{ext: 1'b0, code: 8'h29};
    localparam key_code_t KEY_ESC   = '{ext: 1'b0, code: 8'h76};

    // Index 0 is the least significant entry.
    localparam key_code_t [3:0] DEFAULT_MAP = {KEY_ESC, KEY_SPACE, KEY_RIGHT, KEY_LEFT};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_IGN_E1) || (b == PS2_IGN_AA) || (b == PS2_IGN_FA) ||
               (b == PS2_IGN_FE) || (b == PS2_IGN_00) || (b == PS2_IGN_FF);
    endfunction

endpackage

// File: rtl/keyboard_keymap_if.sv
// Byte-in / key-state-out bundle between the PS/2 receiver side and the
// keymap decoder.
//   rx_data, rx_valid          : received scan-code byte and its strobe
//   key_held                   : per-key held level
//   key_press / key_release    : one-cycle edge pulses per key
//   seq_error                  : one-cycle pulse on timeout or bad prefix
// master = byte producer / key consumer, slave = decoder.
interface keyboard_keymap_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                seq_error;

    modport master (
        output rx_data, rx_valid,
        input  key_held, key_press, key_release, seq_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output key_held, key_press, key_release, seq_error
    );
endinterface

// File: rtl/keyboard_keymap_match.sv
// Combinational key lookup: compares one {ext, code} against every
// KEY_CODES entry; all matching indices are flagged (duplicates allowed).
//   code_i : key identity being looked up
//   hit_o  : bit i set when KEY_CODES[i] equals code_i
module keyboard_keymap_match
    import keymap_pkg::*;
#(
    parameter int unsigned              NUM_KEYS  = 4,
    parameter key_code_t [NUM_KEYS-1:0] KEY_CODES = DEFAULT_MAP
) (
    input  key_code_t           code_i,
    output logic [NUM_KEYS-1:0] hit_o
);

    always_comb begin
        hit_o = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hit_o[i] = (KEY_CODES[i] == code_i);
        end
    end

endmodule

// File: rtl/keyboard_keymap.sv
// PS/2 set-2 scan-code decoder tracking make/break and E0-extended
// sequences for NUM_KEYS configurable keys.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : keyboard_keymap_if slave (rx byte in; held/press/release/
//                seq_error out, all registered)
//   button_left, button_right : only with KEYBOARD_KEYMAP_LEGACY_EN defined;
//                mirror key_held[0] / key_held[1] (needs NUM_KEYS >= 2)
module keyboard_keymap
    import keymap_pkg::*;
#(
    parameter int unsigned              NUM_KEYS       = 4,
    parameter key_code_t [NUM_KEYS-1:0] KEY_CODES      = DEFAULT_MAP,
    parameter int unsigned              TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    keyboard_keymap_if.slave    bus
`ifdef KEYBOARD_KEYMAP_LEGACY_EN
    ,
    output logic                button_left,
    output logic                button_right
`endif
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
        $error("keyboard_keymap: NUM_KEYS must be 1..16");
    end

    kbd_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                err_q, err_d;

    key_code_t           lookup;
    logic [NUM_KEYS-1:0] hit;
    logic                do_make;
    logic                do_break;

    // Ext flag of the completing byte comes from the prefix already seen.
    assign lookup.ext  = (state_q == EXT) || (state_q == EXT_BRK);
    assign lookup.code = bus.rx_data;

    keyboard_keymap_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES)
    ) u_match (
        .code_i (lookup),
        .hit_o  (hit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        press_d   = '0;
        release_d = '0;
        err_d     = 1'b0;
        do_make   = 1'b0;
        do_break  = 1'b0;

        if (bus.rx_valid) begin
            // A byte always wins over a coincident timeout.
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_data == PS2_EXT)      state_d = EXT;
                    else if (bus.rx_data == PS2_BRK) state_d = BRK;
                    else if (!is_ignored(bus.rx_data)) do_make = 1'b1;
                end
                EXT: begin
                    if (bus.rx_data == PS2_BRK) state_d = EXT_BRK;
                    else if (bus.rx_data != PS2_EXT) begin
                        do_make = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    // A new prefix after F0 aborts the break and restarts.
                    if (bus.rx_data == PS2_EXT) begin
                        err_d   = 1'b1;
                        state_d = EXT;
                    end else if (bus.rx_data == PS2_BRK) begin
                        err_d   = 1'b1;
                        state_d = BRK;
                    end else begin
                        do_break = 1'b1;
                        state_d  = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (bus.rx_data == PS2_EXT || bus.rx_data == PS2_BRK) begin
                        err_d = 1'b1;
                    end else begin
                        do_break = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (do_make) begin
            press_d = hit & ~held_q;
            held_d  = held_q | hit;
        end
        if (do_break) begin
            release_d = hit & held_q;
            held_d    = held_q & ~hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            err_q     <= err_d;
        end
    end

    assign bus.key_held    = held_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.seq_error   = err_q;

`ifdef KEYBOARD_KEYMAP_LEGACY_EN
    if (NUM_KEYS < 2) begin : g_bad_legacy
        $error("keyboard_keymap: KEYBOARD_KEYMAP_LEGACY_EN needs NUM_KEYS >= 2");
    end
    assign button_left  = held_q[0];
    assign button_right = held_q[1];
`endif

endmodule

// File: tb/tb_keyboard_keymap.sv
module tb_keyboard_keymap;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keyboard_keymap_if #(.NUM_KEYS(4)) bus();

`ifdef KEYBOARD_KEYMAP_LEGACY_EN
    logic button_left, button_right;
`endif

    keyboard_keymap #(
        .NUM_KEYS       (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef KEYBOARD_KEYMAP_LEGACY_EN
        ,
        .button_left  (button_left),
        .button_right (button_right)
`endif
    );

    // Reference keymap: Left E0 6B, Right E0 74, Space 29, Esc 76.
    logic [8:0] tb_map [4] = '{9'h16B, 9'h174, 9'h029, 9'h076};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: held keys, pending prefix bytes, idle cycles since last byte.
    logic [3:0] m_held;
    logic [7:0] pfx[$];
    int         gap;
    logic [3:0] e_press, e_rel;
    logic       e_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic pfx_has(input logic [7:0] b);
        foreach (pfx[k]) if (pfx[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic ign(input logic [7:0] b);
        return b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    task automatic model_reset();
        m_held = '0; e_press = '0; e_rel = '0; e_err = 1'b0;
        pfx.delete(); gap = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        logic ext, brk;
        e_press = '0; e_rel = '0; e_err = 1'b0;
        if (v) begin
            gap = 0;
            if (b == 8'hE0 || b == 8'hF0) begin
                if (pfx_has(8'hF0)) begin
                    e_err = 1'b1;
                    if (pfx_has(8'hE0)) pfx.delete();
                    else begin pfx.delete(); pfx.push_back(b); end
                end else if (b == 8'hF0 || pfx.size() == 0) begin
                    pfx.push_back(b);
                end
            end else if (!(pfx.size() == 0 && ign(b))) begin
                ext = pfx_has(8'hE0);
                brk = pfx_has(8'hF0);
                for (int i = 0; i < 4; i++) begin
                    if (tb_map[i] == {ext, b}) begin
                        if (brk && m_held[i]) begin m_held[i] = 1'b0; e_rel[i] = 1'b1; end
                        if (!brk && !m_held[i]) begin m_held[i] = 1'b1; e_press[i] = 1'b1; end
                    end
                end
                pfx.delete();
            end
        end else if (pfx.size() != 0) begin
            gap++;
            if (gap == TO) begin e_err = 1'b1; pfx.delete(); gap = 0; end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        rst_n = ~r;
        bus.rx_valid = v;
        bus.rx_data  = b;
        if (r) model_reset(); else model_step(v, b);
        @(posedge clk);
        #1;
        check_eq("held", 32'(bus.key_held), 32'(m_held));
        check_eq("press", 32'(bus.key_press), 32'(e_press));
        check_eq("release", 32'(bus.key_release), 32'(e_rel));
        check_eq("seq_error", 32'(bus.seq_error), 32'(e_err));
`ifdef KEYBOARD_KEYMAP_LEGACY_EN
        check_eq("button_left", 32'(button_left), 32'(m_held[0]));
        check_eq("button_right", 32'(button_right), 32'(m_held[1]));
`endif
        rst_n = 1'b1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h76,
                              8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'h12};

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check_eq("reset_held", 32'(bus.key_held), 32'h0);

        // Space make / break
        send(8'h29);
        check_eq("space_held", 32'(bus.key_held), 32'h4);
        check_eq("space_press", 32'(bus.key_press), 32'h4);
        idle(1);
        send(8'hF0); send(8'h29);
        check_eq("space_release", 32'(bus.key_release), 32'h4);
        idle(1);

        // Extended Left with typematic repeat, then extended break
        send(8'hE0); send(8'h6B);
        check_eq("left_press", 32'(bus.key_press), 32'h1);
        send(8'hE0); send(8'h6B);
        check_eq("left_repeat", 32'(bus.key_press), 32'h0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check_eq("left_release", 32'(bus.key_release), 32'h1);
        send(8'h6B);
        check_eq("plain_6b", 32'(bus.key_held), 32'h0);

        // Right and Space held together
        send(8'hE0); send(8'h74);
        check_eq("right_held", 32'(bus.key_held), 32'h2);
        send(8'h29);
        check_eq("both_held", 32'(bus.key_held), 32'h6);
        send(8'hF0); send(8'h29);
        check_eq("right_kept", 32'(bus.key_held), 32'h2);
        send(8'hE0); send(8'hF0); send(8'h74);

        // Timeout after a lone E0
        send(8'hE0);
        idle(TO - 1);
        check_eq("no_err_early", 32'(bus.seq_error), 32'h0);
        idle(1);
        check_eq("timeout_err", 32'(bus.seq_error), 32'h1);
        send(8'h74);
        check_eq("after_timeout", 32'(bus.key_held), 32'h0);

        // Malformed prefix and ignored bytes
        send(8'hF0); send(8'hF0);
        check_eq("double_f0_err", 32'(bus.seq_error), 32'h1);
        send(8'h29);
        check_eq("unheld_break", 32'(bus.key_release), 32'h0);
        send(8'hE1); send(8'hFA);

        // Reset mid-prefix while Space is held
        send(8'h29); send(8'hE0);
        step(1'b1, 1'b0, 8'h00);
        check_eq("reset_mid", 32'(bus.key_held), 32'h0);
        send(8'h6B);
        check_eq("reset_dropped_e0", 32'(bus.key_held), 32'h0);
        send(8'hE0); send(8'h6B);
        check_eq("left_after_reset", 32'(bus.key_held), 32'h1);

        // Randomized traffic against the model
        for (int it = 0; it < 3000; it++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 1) step(1'b1, 1'b0, 8'h00);
            else if (r < 6) idle(int'($urandom_range(1, 20)));
            else if (r < 8) send(8'($urandom));
            else begin
                send(pool[$urandom_range(0, 12)]);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 2)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
